simplez_kbd_fifo: RTL
=====================

// Module: simplez_kbd_fifo
// PURPOSE
//  Memory-mapped keyboard responder for the Simplez bus: a buffered replacement for the single-byte keyboard registers.
//  Bytes from uart_rx are pushed into a FIFO. The CPU, as bus initiator, reads status/data at TECLADO_STATUS/TECLADO_DATA.
//  Removes byte loss when the program polls slower than the serial line delivers.
//  Sits beside genram on the CPU data bus; its rdata is one input of the CPU read-data mux.
// PARAMETERS
//  STATUS_ADR  9'd510  address of status register
//  DATA_ADR    9'd511  address of data register
//  DEPTH_LOG2  3       FIFO depth = 2**DEPTH_LOG2 bytes (8)
// PORTS
//  clk      in   1   system clock
//  rstn     in   1   reset: synchronous, active-low
//  addr     in   9   bus address (CPU CD field)
//  en       in   1   access strobe; one cycle per CPU data access (EXEC1 of LD/ADD/ST)
//  rw       in   1   1 = read, 0 = write
//  wdata    in   12  write data (CPU accumulator)
//  rdata    out  12  registered read data
//  hit      out  1   combinational: addr is STATUS_ADR or DATA_ADR (CPU read-mux select)
//  rx_rcv   in   1   one-cycle strobe from uart_rx: byte valid
//  rx_data  in   8   byte from uart_rx
//  count    out  DEPTH_LOG2+1  current fill level (debug/LEDs)
// BEHAVIOUR
//  Reset (rstn=0 at clk edge): rdata=0, count=0, rd/wr pointers=0, ovf=0. Stored FIFO contents are don't-care.
//  Access = en & hit. Read latency: rdata updates on the clk edge of the access and is valid the next cycle (same as genram).
//  rdata holds its value until the next read access. Writes and non-hit cycles leave rdata unchanged.
//  Status read: rdata = {8'b0, ovf, full, ~empty, 1'b0} is WRONG encoding; the required encoding is:
//    rdata = {9'b0, ovf, full, ~empty}  (bit0 = data available, bit1 = full, bit2 = overflow sticky).
//  Data read with FIFO non-empty: rdata = {4'b0, head byte}; pop (rd_ptr+1, count-1) on the same edge.
//  Data read with FIFO empty: rdata = 0; no pop; pointers unchanged.
//  Status write (any wdata): clears ovf. Data write: ignored, no state change.
//  Push: rx_rcv=1 and (not full, or a pop occurs on the same edge) -> store rx_data at wr_ptr; wr_ptr+1.
//  rx_rcv=1 while full and no pop on that edge: byte dropped, ovf<=1, FIFO unchanged.
//  Simultaneous push+pop: count unchanged. Popped byte = old head. Pushed byte lands at the tail, also when the FIFO was full.
//  Simultaneous push+pop on an empty FIFO: the pop is void (rdata=0) and the push proceeds (count=1).
//  Simultaneous ovf set (dropped push) and status-write clear: set wins, so ovf=1.
//  Pointers are DEPTH_LOG2 bits and wrap modulo depth. full = (count==2**DEPTH_LOG2); empty = (count==0).
//  en held high for N cycles on DATA_ADR = N pops. The initiator guarantees single-cycle en.
//  Reset mid-operation: all buffered bytes discarded; first access after reset reads status=0.
// STRUCTURE
//  Address constants (STATUS/DATA/LEDS/PANTALLA) go in shared header peripherals/simplez_map.vh; the CPU and all responders include it.
//  One sub-module: simplez_fifo_sync (DW=8, AW=DEPTH_LOG2; push/pop/full/empty/count; registered pointers).
//  Top level holds the address decode, ovf flag and rdata register.
// TESTING
//  1 Reset, then status read -> rdata=12'h000 next cycle; count=0.
//  2 Push 8'h41, status read -> 12'h001; data read -> 12'h041; status read -> 12'h000.
//  3 Push 8'h30..8'h37 (8 bytes) -> status 12'h003. Push 8'h38 -> status 12'h007 and count stays 8.
//    Eight data reads return 30..37 in order. Status write -> 12'h000.
//  4 FIFO full with 8'h30..8'h37; data read and push 8'h99 on the same edge -> rdata=12'h030, count=8, ovf=0.
//    Subsequent reads return 31..37 then 99.
//  5 Empty FIFO; data read and push 8'h55 on the same edge -> rdata=12'h000, count=1; next data read -> 12'h055.
//  6 Push 3 bytes, assert rstn=0 one cycle -> count=0, rdata=0. Pointer wrap: 20 push/pop pairs keep data in order.

Source files
------------

// File: rtl/simplez_kbd_fifo_pkg.sv
// Shared definitions for the Simplez buffered keyboard responder:
// bus addresses, access classification and the status word layout.
package simplez_kbd_fifo_pkg;

    localparam logic [8:0] TECLADO_STATUS = 9'd510;
    localparam logic [8:0] TECLADO_DATA   = 9'd511;
    localparam int         KBD_DEPTH_LOG2 = 3;

    typedef enum logic [2:0] {
        ACC_NONE,
        ACC_STAT_RD,
        ACC_STAT_WR,
        ACC_DATA_RD,
        ACC_DATA_WR
    } acc_e;

    // Classify one bus cycle; anything not addressed to us is ACC_NONE.
    function automatic acc_e decode_acc(input logic en, input logic rw,
                                        input logic is_stat, input logic is_data);
        acc_e a;
        a = ACC_NONE;
        if (en && is_stat) a = rw ? ACC_STAT_RD : ACC_STAT_WR;
        else if (en && is_data) a = rw ? ACC_DATA_RD : ACC_DATA_WR;
        return a;
    endfunction

    // bit0 = data available, bit1 = full, bit2 = sticky overflow.
    function automatic logic [11:0] status_word(input logic ovf, input logic full,
                                                input logic avail);
        return {9'b0, ovf, full, avail};
    endfunction

endpackage

// File: rtl/simplez_fifo_sync.sv
// Single-clock FIFO with registered pointers and fill counter.
// A push into a full FIFO is accepted only when a real pop happens on
// the same edge; a pop on an empty FIFO is void.
module simplez_fifo_sync #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count,
    output logic          o_popped,
    output logic          o_drop
);

    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_popped  = w_pop_ok;
    assign o_drop    = i_push & ~w_push_ok;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

    // Pointer and fill-level bookkeeping; pointers wrap modulo depth.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/simplez_kbd_fifo.sv
// Buffered keyboard responder on the Simplez data bus. Received UART
// bytes queue in a FIFO; the CPU polls status and pops bytes by reading
// the data address. rdata is registered (one-cycle latency, like genram).
module simplez_kbd_fifo
    import simplez_kbd_fifo_pkg::*;
#(
    parameter logic [8:0] STATUS_ADR = TECLADO_STATUS,
    parameter logic [8:0] DATA_ADR   = TECLADO_DATA,
    parameter int         DEPTH_LOG2 = KBD_DEPTH_LOG2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [8:0]          addr,
    input  logic                en,
    input  logic                rw,
    input  logic [11:0]         wdata,
    output logic [11:0]         rdata,
    output logic                hit,
    input  logic                rx_rcv,
    input  logic [7:0]          rx_data,
    output logic [DEPTH_LOG2:0] count
);

    logic        w_is_stat;
    logic        w_is_data;
    acc_e        w_acc;
    logic [7:0]  w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_popped;
    logic        w_drop;
    logic        w_unused;
    logic [11:0] r_rdata;
    logic        r_ovf;

    assign w_is_stat = (addr == STATUS_ADR);
    assign w_is_data = (addr == DATA_ADR);
    assign hit       = w_is_stat | w_is_data;
    assign w_acc     = decode_acc(en, rw, w_is_stat, w_is_data);
    assign rdata     = r_rdata;
    // A status write clears overflow whatever value is written.
    assign w_unused  = ^wdata;

    simplez_fifo_sync #(
        .DW (8),
        .AW (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .i_push   (rx_rcv),
        .i_wdata  (rx_data),
        .i_pop    (w_acc == ACC_DATA_RD),
        .o_rdata  (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (count),
        .o_popped (w_popped),
        .o_drop   (w_drop)
    );

    // Read-data register: loads only on read accesses, holds otherwise.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rdata <= '0;
        end else if (w_acc == ACC_STAT_RD) begin
            r_rdata <= status_word(r_ovf, w_full, ~w_empty);
        end else if (w_acc == ACC_DATA_RD) begin
            r_rdata <= w_popped ? {4'b0, w_head} : 12'h000;
        end
    end

    // Sticky overflow: a dropped byte sets it and beats a same-edge clear.
    always_ff @(posedge clk) begin
        if (!rstn)                    r_ovf <= 1'b0;
        else if (w_drop)              r_ovf <= 1'b1;
        else if (w_acc == ACC_STAT_WR) r_ovf <= 1'b0;
    end

endmodule
